controlador_exibicao_leds: RTL

- Sequences the LED-display phase of jogo_desafio_memoria.
- Walks the sequence memory from address 0 to the current round limit and shows each stored 4-bit pattern on leds for T_ON cycles, then blanks them for T_OFF cycles.
- Signals completion so the main control unit can move on to waiting for player input.
- Sits between unidade_controle (start/abort) and the sequence ROM/RAM (address out, data in).

---
 rtl/controlador_exibicao_leds_pkg.sv | 20 ++
 rtl/controlador_exibicao_leds_if.sv | 38 +++
 rtl/controlador_exibicao_leds_contador.sv | 27 ++
 rtl/controlador_exibicao_leds.sv | 134 +++++++++++++
 4 files changed

// File: rtl/controlador_exibicao_leds_pkg.sv
// rtl/controlador_exibicao_leds_pkg.sv - state encoding, default durations and fast-mode helper
package pkg_exibicao;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam int T_ON_PADRAO  = 500;
    localparam int T_OFF_PADRAO = 250;

    // Fast mode halves a duration but never lets it collapse to zero cycles.
    function automatic int metade_min1(input int t);
        return (t / 2 < 1) ? 1 : t / 2;
    endfunction

endpackage

// File: rtl/controlador_exibicao_leds_if.sv
// rtl/controlador_exibicao_leds_if.sv - control, memory and LED signals of the display sequencer (pausa with DISPLAY_PAUSE_EN)
interface controlador_exibicao_leds_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic              abortar;
    logic              modo_rapido;
    logic [ADDR_W-1:0] limite_rodada;
    logic [DATA_W-1:0] dado_memoria;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              exibindo;
    logic              fim_exibicao;

`ifdef DISPLAY_PAUSE_EN
    logic              pausa;

    modport master (
        output iniciar, abortar, modo_rapido, limite_rodada, dado_memoria, pausa,
        input  endereco, leds, exibindo, fim_exibicao
    );
    modport slave (
        input  iniciar, abortar, modo_rapido, limite_rodada, dado_memoria, pausa,
        output endereco, leds, exibindo, fim_exibicao
    );
`else
    modport master (
        output iniciar, abortar, modo_rapido, limite_rodada, dado_memoria,
        input  endereco, leds, exibindo, fim_exibicao
    );
    modport slave (
        input  iniciar, abortar, modo_rapido, limite_rodada, dado_memoria,
        output endereco, leds, exibindo, fim_exibicao
    );
`endif

endinterface

// File: rtl/controlador_exibicao_leds_contador.sv
// rtl/controlador_exibicao_leds_contador.sv - loadable down-counter with enable and zero flag
module contador_tempo_exibicao #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carregar,
    input  logic         habilitar,
    input  logic [W-1:0] valor,
    output logic         zero
);

    logic [W-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (carregar) begin
            contagem <= valor;
        end else if (habilitar && !zero) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/controlador_exibicao_leds.sv
// rtl/controlador_exibicao_leds.sv - shows stored patterns 0..limit on the LEDs; DISPLAY_PAUSE_EN adds a pause input
module controlador_exibicao_leds
    import pkg_exibicao::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO
) (
    input  logic                         clock,
    input  logic                         reset,
    controlador_exibicao_leds_if.slave   bus
);

    localparam int TW = $clog2(T_ON + 1);
    localparam logic [TW-1:0] CARGA_ON_N  = TW'(T_ON - 1);
    localparam logic [TW-1:0] CARGA_ON_R  = TW'(metade_min1(T_ON) - 1);
    localparam logic [TW-1:0] CARGA_OFF_N = TW'(T_OFF - 1);
    localparam logic [TW-1:0] CARGA_OFF_R = TW'(metade_min1(T_OFF) - 1);

    estado_t           estado;
    estado_t           estado_prox;
    logic [ADDR_W-1:0] endereco_q;
    logic [ADDR_W-1:0] limite_q;
    logic              modo_q;
    logic [DATA_W-1:0] leds_q;
    logic              primeiro;
    logic              carregar;
    logic              habilitar;
    logic [TW-1:0]     valor_carga;
    logic              zero;
    logic              pausa_ativa;

`ifdef DISPLAY_PAUSE_EN
    assign pausa_ativa = bus.pausa;
`else
    assign pausa_ativa = 1'b0;
`endif

    contador_tempo_exibicao #(.W(TW)) u_contador (
        .clock     (clock),
        .reset     (reset),
        .carregar  (carregar),
        .habilitar (habilitar),
        .valor     (valor_carga),
        .zero      (zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        carregar    = 1'b0;
        habilitar   = 1'b0;
        valor_carga = '0;
        case (estado)
            OCIOSO: begin
                if (bus.iniciar) estado_prox = CARREGA;
            end
            CARREGA: begin
                estado_prox = ACESO;
                carregar    = 1'b1;
                valor_carga = modo_q ? CARGA_ON_R : CARGA_ON_N;
            end
            ACESO: begin
                if (!pausa_ativa) begin
                    if (zero) begin
                        estado_prox = APAGADO;
                        carregar    = 1'b1;
                        valor_carga = modo_q ? CARGA_OFF_R : CARGA_OFF_N;
                    end else begin
                        habilitar = 1'b1;
                    end
                end
            end
            APAGADO: begin
                if (!pausa_ativa) begin
                    if (zero) begin
                        estado_prox = (endereco_q == limite_q) ? FIM : CARREGA;
                    end else begin
                        habilitar = 1'b1;
                    end
                end
            end
            FIM:     estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
        // Abort wins over start, over pause and over the final transition.
        if (bus.abortar) begin
            estado_prox = OCIOSO;
            carregar    = 1'b0;
            habilitar   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco_q <= '0;
            limite_q   <= '0;
            modo_q     <= 1'b0;
            leds_q     <= '0;
            primeiro   <= 1'b0;
        end else if (bus.abortar) begin
            endereco_q <= '0;
            leds_q     <= '0;
            primeiro   <= 1'b0;
        end else begin
            if (estado == OCIOSO && bus.iniciar) begin
                limite_q   <= bus.limite_rodada;
                modo_q     <= bus.modo_rapido;
                endereco_q <= '0;
            end
            if (estado == CARREGA) primeiro <= 1'b1;
            if (estado == ACESO && primeiro) begin
                leds_q   <= bus.dado_memoria;
                primeiro <= 1'b0;
            end
            if (estado == APAGADO && estado_prox == CARREGA) endereco_q <= endereco_q + 1'b1;
        end
    end

    // Read data arrives in the first lit cycle; it is passed through then and held afterwards.
    assign bus.leds         = (estado == ACESO) ? (primeiro ? bus.dado_memoria : leds_q) : '0;
    assign bus.endereco     = endereco_q;
    assign bus.exibindo     = (estado != OCIOSO);
    assign bus.fim_exibicao = (estado == FIM);

endmodule
